// File: rtl/lcd_pattern_gen.sv
// lcd_pattern_gen
// Downstream stage of the LCD timing generator. It follows DE/HSYNC/VSYNC to
// track the active-pixel X/Y position. It drives RGB565 test patterns and
// re-timed syncs to the panel. Every output is the registered result of the
// inputs sampled one pixel clock earlier.
// The pattern is only latched at frame start, so a pattern switch never tears.

module lcd_pattern_gen #(
  parameter int unsigned H_ACTIVE    = 800,  // active pixels per line, multiple of 8
  parameter int unsigned V_ACTIVE    = 480,  // active lines per frame
  parameter int unsigned AUTO_FRAMES = 60,   // frames per pattern in auto-cycle mode
  parameter bit          SYNC_LOW    = 1'b1  // 1: syncs active-low, 0: active-high
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       IN_DE,
  input  logic       IN_HSYNC,
  input  logic       IN_VSYNC,
  input  logic [1:0] MODE,
  input  logic       AUTO,
  output logic       LCD_DE,
  output logic       LCD_HSYNC,
  output logic       LCD_VSYNC,
  output logic [4:0] LCD_R,
  output logic [5:0] LCD_G,
  output logic [4:0] LCD_B,
  output logic       FRAME_TICK
);

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GRID  = 2'd1,
    PAT_GRAD  = 2'd2,
    PAT_CHECK = 2'd3
  } pattern_e;

  // The pattern equations read X[9:5] and Y[8:3]. The counters are therefore
  // at least that wide, even for small panels.
  localparam int unsigned XW = ($clog2(H_ACTIVE) > 10) ? $clog2(H_ACTIVE) : 10;
  localparam int unsigned YW = ($clog2(V_ACTIVE) > 9) ? $clog2(V_ACTIVE) : 9;
  localparam logic [XW-1:0] X_MAX = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(V_ACTIVE - 1);

  // The colour-bar width is tracked by a small counter that runs next to X.
  // No divider is needed.
  localparam int unsigned BAR_LEN  = H_ACTIVE / 8;
  localparam int unsigned BW       = (BAR_LEN > 1) ? $clog2(BAR_LEN) : 1;
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_LEN - 1);

  localparam int unsigned FW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(AUTO_FRAMES - 1);

  // Idle level of a sync line. This is also the reset value of the sync history.
  localparam logic SYNC_IDLE = SYNC_LOW;

  // Position state
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [BW-1:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]    bar_idx_q, bar_idx_d;

  // Pattern selection state
  pattern_e      pat_q, pat_d;
  logic [FW-1:0] frm_cnt_q, frm_cnt_d;

  // Output registers. The delayed DE/VSYNC values also serve as edge history.
  logic          de_q, hs_q, vs_q;
  logic          tick_q, tick_d;
  logic [4:0]    r_q, r_d;
  logic [5:0]    g_q, g_d;
  logic [4:0]    b_q, b_d;

  logic          vs_now_on;
  logic          vs_prev_on;
  logic          frame_start;
  logic          de_fall;
  logic          white;

  assign vs_now_on   = SYNC_LOW ? ~IN_VSYNC : IN_VSYNC;
  assign vs_prev_on  = SYNC_LOW ? ~vs_q : vs_q;
  assign frame_start = vs_now_on & ~vs_prev_on;
  assign de_fall     = de_q & ~IN_DE;

  // Horizontal position and bar index: count DE pixels, saturate, clear in blanking
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    x_d       = '0;
    bar_cnt_d = '0;
    bar_idx_d = '0;
    if (IN_DE) begin
      x_d = (x_q == X_MAX) ? x_q : x_q + XW'(1);
      if (bar_cnt_q == BAR_LAST) begin
        bar_cnt_d = '0;
        bar_idx_d = (bar_idx_q == 3'd7) ? bar_idx_q : bar_idx_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + BW'(1);
        bar_idx_d = bar_idx_q;
      end
    end
  end

  // Vertical position: advance at end of each active line, restart at frame start
  always_comb begin
    y_d = y_q;
    if (frame_start) begin
      y_d = '0;
    end else if (de_fall && (y_q != Y_MAX)) begin
      y_d = y_q + YW'(1);
    end
  end

  // Pattern latch: follow MODE at frame start, or step through patterns in auto mode
  always_comb begin
    pat_d     = pat_q;
    frm_cnt_d = AUTO ? frm_cnt_q : '0;
    tick_d    = frame_start;
    if (frame_start) begin
      if (!AUTO) begin
        pat_d = pattern_e'(MODE);
      end else if (frm_cnt_q == FRAME_LAST) begin
        frm_cnt_d = '0;
        pat_d     = pattern_e'(pat_q + 2'd1);
      end else begin
        frm_cnt_d = frm_cnt_q + FW'(1);
      end
    end
  end

  // Pixel colour from current X/Y and latched pattern; black outside active video
  always_comb begin
    r_d   = '0;
    g_d   = '0;
    b_d   = '0;
    white = 1'b0;
    if (IN_DE) begin
      unique case (pat_q)
        PAT_BARS: begin
          // white, yellow, cyan, green, magenta, red, blue, black
          r_d = {5{~bar_idx_q[1]}};
          g_d = {6{~bar_idx_q[2]}};
          b_d = {5{~bar_idx_q[0]}};
        end
        PAT_GRID: begin
          white = (x_q[4:0] == 5'd0) || (y_q[4:0] == 5'd0) ||
                  (x_q == X_MAX) || (y_q == Y_MAX);
        end
        PAT_GRAD: begin
          r_d = x_q[9:5];
          g_d = y_q[8:3];
          b_d = ~x_q[9:5];
        end
        PAT_CHECK: begin
          white = x_q[5] ^ y_q[5];
        end
      endcase
      if (white) begin
        r_d = 5'd31;
        g_d = 6'd63;
        b_d = 5'd31;
      end
    end
  end

  // State and output registers; reset puts syncs at their idle level
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      x_q       <= '0;
      y_q       <= '0;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
      pat_q     <= PAT_BARS;
      frm_cnt_q <= '0;
      de_q      <= 1'b0;
      hs_q      <= SYNC_IDLE;
      vs_q      <= SYNC_IDLE;
      tick_q    <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments; every register samples pre-edge values.
      x_q       <= x_d;
      y_q       <= y_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      pat_q     <= pat_d;
      frm_cnt_q <= frm_cnt_d;
      de_q      <= IN_DE;
      hs_q      <= IN_HSYNC;
      vs_q      <= IN_VSYNC;
      tick_q    <= tick_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
    end
  end

  assign LCD_DE     = de_q;
  assign LCD_HSYNC  = hs_q;
  assign LCD_VSYNC  = vs_q;
  assign LCD_R      = r_q;
  assign LCD_G      = g_q;
  assign LCD_B      = b_q;
  assign FRAME_TICK = tick_q;

endmodule
